// File: rtl/frame_capture_ctrl_pkg.sv
// Shared constants for the camera frame-capture path: FSM state encodings,
// bank sizes and default address widths.
package frame_capture_ctrl_pkg;

  // Capture sequencer states
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOF = 2'd1;
  localparam logic [1:0] CAPTURE  = 2'd2;

  // Words held by one frame-buffer bank and one min/max bank
  localparam int FRAME_WORDS = 19200;
  localparam int MM_WORDS    = 4800;

  // Default widths: 2^15 covers 19200 words, 2^13 covers 4800 entries
  localparam int FRAME_AW_DEF = 15;
  localparam int MM_AW_DEF    = 13;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/frame_capture_ctrl_vsync_edge_detect.sv
// Registers camera vsync and flags its edges. vsync low is the active
// frame, so the falling edge starts a frame and the rising edge ends it.
module vsync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic sof,
  output logic eof
);

  logic vsync_q;

  // Delay vsync by one cycle; reset to 0 so no start-of-frame is seen
  // until a genuine high-to-low transition occurs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
    end
  end

  assign sof = vsync_q & ~vsync;
  assign eof = ~vsync_q & vsync;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Camera capture sequencer: decides which frames get written, gates the
// frame-buffer and min/max write strobes, and ping-pongs two banks so a
// consumer always reads a complete, stable frame from rd_bank.
module frame_capture_ctrl
  import frame_capture_ctrl_pkg::*;
#(
  parameter int FRAME_AW = FRAME_AW_DEF,
  parameter int MM_AW    = MM_AW_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                p_clock,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                cam_we,
  input  logic [FRAME_AW-1:0] cam_addr,
  input  logic                cam_mm_we,
  input  logic [MM_AW-1:0]    cam_mm_addr,
  input  logic                mode_cont,
  input  logic                arm,
  input  logic                frame_ack,
  output logic                mem_we,
  output logic [FRAME_AW:0]   mem_addr,
  output logic                mm_we,
  output logic [MM_AW:0]      mm_addr,
  output logic                rd_bank,
  output logic                frame_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_count,
  output logic [CNT_W-1:0]    drop_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       wr_bank;
  logic       sof;
  logic       eof;
  logic       capturing;
  logic       frame_done;
  logic       swap;

  vsync_edge_detect u_edge (
    .clk   (p_clock),
    .rst_n (rst_n),
    .vsync (vsync),
    .sof   (sof),
    .eof   (eof)
  );

  assign capturing  = (state == CAPTURE);
  assign frame_done = capturing & eof;
  // Publish only if the consumer has nothing outstanding or is releasing it now
  assign swap       = frame_done & (~frame_ready | frame_ack);

  assign mem_we   = cam_we & capturing;
  assign mm_we    = cam_mm_we & capturing;
  assign mem_addr = {wr_bank, cam_addr};
  assign mm_addr  = {wr_bank, cam_mm_addr};
  assign busy     = (state != IDLE);

  // Next-state logic; WAIT_SOF ignores eof so a partial frame is never taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mode_cont || arm) state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (sof) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (eof) state_nxt = mode_cont ? WAIT_SOF : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bank ping-pong and frame_ready handshake; banks always differ
  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_ready <= 1'b0;
    end else if (swap) begin
      rd_bank     <= wr_bank;
      wr_bank     <= ~wr_bank;
      frame_ready <= 1'b1;
    end else if (frame_ack) begin
      frame_ready <= 1'b0;
    end
  end

  // Completed-frame counter wraps; drop counter saturates at all-ones
  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + CNT_ONE;
      if (!swap && (drop_count != {CNT_W{1'b1}})) begin
        drop_count <= drop_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl: a scoreboard queue of
// expected write-port transactions popped by a monitor, plus directed
// status checks after each frame.
module tb_frame_capture_ctrl;

  localparam int FRAME_AW = 15;
  localparam int MM_AW    = 13;
  localparam int CNT_W    = 8;

  typedef struct packed {
    logic              we;
    logic              mmwe;
    logic [FRAME_AW:0] addr;
    logic [MM_AW:0]    mmaddr;
  } wr_t;

  logic                p_clock = 1'b0;
  logic                rst_n;
  logic                vsync;
  logic                cam_we;
  logic [FRAME_AW-1:0] cam_addr;
  logic                cam_mm_we;
  logic [MM_AW-1:0]    cam_mm_addr;
  logic                mode_cont;
  logic                arm;
  logic                frame_ack;
  logic                mem_we;
  logic [FRAME_AW:0]   mem_addr;
  logic                mm_we;
  logic [MM_AW:0]      mm_addr;
  logic                rd_bank;
  logic                frame_ready;
  logic                busy;
  logic [CNT_W-1:0]    frame_count;
  logic [CNT_W-1:0]    drop_count;

  wr_t exp_q[$];
  int  tests  = 0;
  int  fails  = 0;
  bit  mon_en = 1'b1;

  frame_capture_ctrl #(
    .FRAME_AW (FRAME_AW),
    .MM_AW    (MM_AW),
    .CNT_W    (CNT_W)
  ) dut (
    .p_clock     (p_clock),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .cam_we      (cam_we),
    .cam_addr    (cam_addr),
    .cam_mm_we   (cam_mm_we),
    .cam_mm_addr (cam_mm_addr),
    .mode_cont   (mode_cont),
    .arm         (arm),
    .frame_ack   (frame_ack),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mm_we       (mm_we),
    .mm_addr     (mm_addr),
    .rd_bank     (rd_bank),
    .frame_ready (frame_ready),
    .busy        (busy),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #5 p_clock = ~p_clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: whenever the write port is strobed (or should be), pop and compare
  always @(negedge p_clock) begin
    if (mon_en && rst_n && (cam_we || cam_mm_we || mem_we || mm_we)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: mem_we=%0b mm_we=%0b addr=%h, nothing expected",
                 mem_we, mm_we, mem_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({mem_we, mm_we, mem_addr, mm_addr} !== e) begin
          fails++;
          $display("[TB] FAIL write_port: got we=%0b mmwe=%0b addr=%h mmaddr=%h, expected we=%0b mmwe=%0b addr=%h mmaddr=%h",
                   mem_we, mm_we, mem_addr, mm_addr, e.we, e.mmwe, e.addr, e.mmaddr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge p_clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    cam_we = 1'b0; cam_mm_we = 1'b0; arm = 1'b0; frame_ack = 1'b0;
    cam_addr = '0; cam_mm_addr = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One camera frame: sof cycle (with a stray strobe that must be gated),
  // `pulses` write strobes, eof cycle (optional ack), then inter-frame gap.
  // cap/bank are the expected gating and write bank for this frame.
  task automatic applyStimulus(input int pulses, input logic cap, input logic bank,
                               input logic ack_eof, input logic arm_mid);
    wr_t e;
    vsync = 1'b0;
    cam_we = 1'b1; cam_mm_we = 1'b1;
    cam_addr = 15'h7FFF; cam_mm_addr = 13'h1FFF;
    e = '{we: 1'b0, mmwe: 1'b0, addr: {bank, 15'h7FFF}, mmaddr: {bank, 13'h1FFF}};
    exp_q.push_back(e);
    tick();
    cam_we = 1'b0; cam_mm_we = 1'b0;
    for (int i = 0; i < pulses; i++) begin
      cam_we      = 1'b1;
      cam_mm_we   = (i % 2 == 0);
      cam_addr    = FRAME_AW'(100 + i * 7);
      cam_mm_addr = MM_AW'(i * 3 + 1);
      arm         = arm_mid && (i == 0);
      e = '{we: cap, mmwe: cap & (i % 2 == 0),
            addr: {bank, FRAME_AW'(100 + i * 7)}, mmaddr: {bank, MM_AW'(i * 3 + 1)}};
      exp_q.push_back(e);
      tick();
      cam_we = 1'b0; cam_mm_we = 1'b0; arm = 1'b0;
      tick();
    end
    vsync = 1'b1;
    frame_ack = ack_eof;
    tick();
    frame_ack = 1'b0;
    repeat (3) tick();
  endtask

  task automatic ackPulse();
    tick();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  initial begin
    vsync = 1'b1; mode_cont = 1'b0;
    doReset();

    // Reset state
    checkOutput("reset_rd_bank", 32'(rd_bank), 1);
    checkOutput("reset_frame_ready", 32'(frame_ready), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_frame_count", 32'(frame_count), 0);
    checkOutput("reset_drop_count", 32'(drop_count), 0);

    // Continuous mode, three frames, no ack
    mode_cont = 1'b1;
    tick();
    checkOutput("t1_busy", 32'(busy), 1);
    applyStimulus(10, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_f1_rd_bank", 32'(rd_bank), 0);
    checkOutput("t1_f1_ready", 32'(frame_ready), 1);
    checkOutput("t1_f1_count", 32'(frame_count), 1);
    applyStimulus(10, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(10, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_f3_rd_bank", 32'(rd_bank), 0);
    checkOutput("t1_f3_count", 32'(frame_count), 3);
    checkOutput("t1_f3_drops", 32'(drop_count), 2);
    ackPulse();
    checkOutput("t1_ack_clears_ready", 32'(frame_ready), 0);

    // Continuous mode with a timely ack after each frame
    applyStimulus(4, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_f4_rd_bank", 32'(rd_bank), 1);
    ackPulse();
    checkOutput("t2_f4_ack", 32'(frame_ready), 0);
    applyStimulus(4, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_f5_rd_bank", 32'(rd_bank), 0);
    ackPulse();
    applyStimulus(4, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_f6_rd_bank", 32'(rd_bank), 1);
    checkOutput("t2_drops_unchanged", 32'(drop_count), 2);
    checkOutput("t2_count", 32'(frame_count), 6);

    // Enable mid-frame: first eof ignored
    mode_cont = 1'b0;
    doReset();
    repeat (2) tick();
    vsync = 1'b0;
    repeat (2) tick();
    mode_cont = 1'b1;
    tick();
    cam_we = 1'b1; cam_addr = 15'h0042;
    exp_q.push_back('{we: 1'b0, mmwe: 1'b0, addr: {1'b0, 15'h0042}, mmaddr: '0});
    tick();
    cam_we = 1'b0;
    vsync = 1'b1;
    repeat (3) tick();
    checkOutput("t3_partial_count", 32'(frame_count), 0);
    checkOutput("t3_partial_ready", 32'(frame_ready), 0);
    checkOutput("t3_busy", 32'(busy), 1);
    applyStimulus(4, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_full_count", 32'(frame_count), 1);
    checkOutput("t3_full_rd_bank", 32'(rd_bank), 0);

    // Single-shot
    mode_cont = 1'b0;
    doReset();
    applyStimulus(3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_unarmed_count", 32'(frame_count), 0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checkOutput("t4_armed_busy", 32'(busy), 1);
    applyStimulus(6, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_shot_count", 32'(frame_count), 1);
    checkOutput("t4_shot_idle", 32'(busy), 0);
    applyStimulus(6, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_second_count", 32'(frame_count), 1);
    checkOutput("t4_second_idle", 32'(busy), 0);

    // eof coincident with ack while a frame is outstanding
    mode_cont = 1'b1;
    tick();
    applyStimulus(5, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_swap_rd_bank", 32'(rd_bank), 1);
    checkOutput("t5_swap_ready", 32'(frame_ready), 1);
    checkOutput("t5_swap_drops", 32'(drop_count), 0);
    checkOutput("t5_swap_count", 32'(frame_count), 2);
    applyStimulus(5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_drop_count", 32'(drop_count), 1);
    checkOutput("t5_drop_rd_bank", 32'(rd_bank), 1);

    // Asynchronous reset mid-capture
    vsync = 1'b0;
    tick();
    mon_en = 1'b0;
    cam_we = 1'b1; cam_addr = 15'h0123;
    #2;
    checkOutput("t6_we_before_reset", 32'(mem_we), 1);
    checkOutput("t6_addr_before_reset", 32'(mem_addr), 32'h0123);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_we_in_reset", 32'(mem_we), 0);
    checkOutput("t6_busy_in_reset", 32'(busy), 0);
    checkOutput("t6_rd_bank_in_reset", 32'(rd_bank), 1);
    checkOutput("t6_ready_in_reset", 32'(frame_ready), 0);
    checkOutput("t6_counts_in_reset", {16'h0, frame_count, drop_count}, 0);
    cam_we = 1'b0; vsync = 1'b1;
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Drop-counter saturation
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_publish_ready", 32'(frame_ready), 1);
    for (int n = 0; n < 255; n++) applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_drops_255", 32'(drop_count), 255);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_drops_saturated", 32'(drop_count), 255);
    checkOutput("t6_count_wrapped", 32'(frame_count), 1);
    checkOutput("t6_rd_bank", 32'(rd_bank), 0);

    repeat (2) tick();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Sequences the camera capture path: decides which frames are written and gates the frame-buffer and min/max write strobes.
- Ping-pongs two frame-buffer banks and two min/max banks, so a downstream consumer (motion detector / display) reads one complete, stable frame while the next frame is captured.
- Sits between the camera reader outputs and the two memories, and runs in the pixel clock domain.

Parameters:
- FRAME_AW, 15, camera frame-buffer word address width (19200 words per bank).
- MM_AW, 13, camera min/max address width (4800 entries per bank).
- CNT_W, 8, width of the frame and drop counters.

Ports:
- p_clock  in  1  pixel clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- vsync  in  1  camera vsync (high = inter-frame).
- cam_we  in  1  frame-buffer write strobe from the camera reader.
- cam_addr  in  FRAME_AW  frame-buffer address from the camera reader.
- cam_mm_we  in  1  min/max write strobe from the camera reader.
- cam_mm_addr  in  MM_AW  min/max write address from the camera reader.
- mode_cont  in  1  1 = capture every frame; 0 = single-shot.
- arm  in  1  single-cycle pulse requesting one frame (single-shot mode).
- frame_ack  in  1  single-cycle pulse: consumer has released rd_bank.
- mem_we  out  1  gated frame-buffer write enable.
- mem_addr  out  FRAME_AW+1  {wr_bank, cam_addr}.
- mm_we  out  1  gated min/max write enable.
- mm_addr  out  MM_AW+1  {wr_bank, cam_mm_addr}.
- rd_bank  out  1  bank holding the last complete frame.
- frame_ready  out  1  rd_bank holds a complete, unacknowledged frame.
- busy  out  1  state != IDLE.
- frame_count  out  CNT_W  completed frames, wraps.
- drop_count  out  CNT_W  frames discarded, saturates at all-ones.

Behaviour:
- **Reset (async, rst_n=0):**
  - state=IDLE, wr_bank=0, rd_bank=1.
  - frame_ready=0, frame_count=0, drop_count=0.
  - vsync_q=0, so no falling edge is detected until a real high-to-low transition.
  - Reset mid-frame abandons the frame; memory contents are undefined.
- **Edge detection:**
  - sof = vsync_q & ~vsync.
  - eof = ~vsync_q & vsync.
  - vsync_q registers vsync every cycle.
- **Write gating:** combinational, zero latency, so strobes stay aligned with the reader's data.
  - mem_we = cam_we & (state==CAPTURE).
  - mm_we = cam_mm_we & (state==CAPTURE).
  - Both addresses are always driven, with wr_bank as the MSB.
- **IDLE:**
  - If mode_cont=1 or arm=1, go to WAIT_SOF.
  - arm is ignored in every other state.
- **WAIT_SOF:**
  - On sof, go to CAPTURE.
  - eof is ignored here, so a partial frame is never captured after enabling mid-frame.
- **CAPTURE, on eof:**
  - frame_count increments.
  - If frame_ready=0, or frame_ack=1 in the same cycle:
    - rd_bank<=wr_bank, wr_bank<=~wr_bank, frame_ready<=1.
  - Otherwise (consumer still holds rd_bank):
    - No swap; drop_count increments, saturating.
    - frame_ready stays 1, and the next frame overwrites wr_bank.
  - Next state is WAIT_SOF if mode_cont=1, else IDLE.
- **Mode change:** deasserting mode_cont mid-CAPTURE finishes the current frame, then goes to IDLE.
- **frame_ack:**
  - When frame_ready=1 and no eof swap occurs, it clears frame_ready next cycle.
  - When frame_ready=0 it is ignored.
  - If ack coincides with an eof swap, frame_ready stays 1 and the new frame is published.
- **Invariant:** wr_bank != rd_bank at all times after reset.
- **Extra edges:** sof/eof edges beyond one per frame are handled only by the state they arrive in; no queuing.

Decomposition:
- **Shared package:**
  - State enum {IDLE, WAIT_SOF, CAPTURE}.
  - FRAME_WORDS=19200 and MM_WORDS=4800.
  - FRAME_AW/MM_AW defaults.
- **Sub-module vsync_edge_detect:** the vsync_q register plus the sof/eof outputs. It is reused by later frame-domain blocks.
- All other logic stays in frame_capture_ctrl.

Test Plan:
1. Reset, mode_cont=1, three vsync frames each with 10 cam_we pulses, no ack:
   - frame 1 is published with rd_bank=0, frame_ready=1, frame_count=1.
   - frames 2 and 3 are written to bank 1 with drop_count=2.
   - all mem_addr MSB = 0 during frame 1.
2. Continuous mode with frame_ack pulsed 5 cycles after each frame_ready:
   - rd_bank alternates 0,1,0 and drop_count stays 0.
   - mem_we mirrors cam_we only between sof and eof.
3. Enable mode_cont while vsync=0 mid-frame:
   - mem_we=0 until the next sof.
   - the first eof is ignored and frame_count stays 0 until the first full frame.
4. Single-shot: arm pulse, then two frames:
   - only the first is captured and the block returns to IDLE with busy=0, frame_count=1.
   - a second arm during CAPTURE has no effect.
5. eof coincident with frame_ack while frame_ready=1:
   - swap occurs, frame_ready stays 1, drop_count unchanged.
6. Assert rst_n=0 mid-CAPTURE with cam_we=1:
   - mem_we drops immediately (async) and all outputs return to reset values.
   - 256 consecutive drops leave drop_count=255.
